// File: rtl/lc3b_types.sv
// Shared line-level types for the LC-3b memory side.
package lc3b_types;
  localparam int LINE_BYTES = 16;

  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_addr;
  typedef logic [15:0]  lc3b_line_sel;

  typedef struct packed {
    logic          we;
    lc3b_line_addr adr;
    lc3b_line_sel  sel;
    lc3b_line      dat;
  } lc3b_line_req;
endpackage

// File: rtl/wb_line_array.sv
// DEPTH x 128-bit line store, split into byte lanes with per-lane write enable
// and a registered read port that holds its value between reads.
module wb_line_array
  import lc3b_types::*;
#(
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  lc3b_line_addr rd_adr,
  output lc3b_line      rd_dat,
  input  logic          wr_en,
  input  lc3b_line_addr wr_adr,
  input  lc3b_line_sel  wr_sel,
  input  lc3b_line      wr_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] rd_idx, wr_idx;
  assign rd_idx = rd_adr[AW-1:0];
  assign wr_idx = wr_adr[AW-1:0];

  for (genvar b = 0; b < LINE_BYTES; b++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
      if (wr_en && wr_sel[b]) mem[wr_idx] <= wr_dat[8*b +: 8];
    end

    always_ff @(posedge clk) begin
      if (!rst_n)     q <= '0;
      else if (rd_en) q <= mem[rd_idx];
    end

    assign rd_dat[8*b +: 8] = q;
  end
endmodule

// File: rtl/wb_line_responder.sv
// Wishbone line slave: fixed-latency reads/writes of 128-bit lines, RTY for
// out-of-range addresses, abort on CYC drop, and a release state per request.
module wb_line_responder
  import lc3b_types::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_cyc,
  input  logic          wb_stb,
  input  logic          wb_we,
  input  lc3b_line_addr wb_adr,
  input  lc3b_line_sel  wb_sel,
  input  lc3b_line      wb_dat_m,
  output lc3b_line      wb_dat_s,
  output logic          wb_ack,
  output logic          wb_rty
);
  typedef enum logic [2:0] {IDLE, WAIT, ACK, RETRY, RELEASE} state_t;

  localparam lc3b_line_addr LAST_ADR = 12'(DEPTH - 1);

  state_t       state;
  logic [3:0]   cnt;
  lc3b_line_req req;

  logic          accept, in_range, rd_en, wr_en;
  lc3b_line_addr rd_adr;

  assign accept   = (state == IDLE) && wb_cyc && wb_stb;
  assign in_range = (wb_adr <= LAST_ADR);

  // Read is launched one cycle ahead of ACK so the registered data lines up.
  always_comb begin
    rd_en  = 1'b0;
    rd_adr = req.adr;
    if (state == IDLE) begin
      rd_adr = wb_adr;
      rd_en  = accept && in_range && !wb_we && (LATENCY == 1);
    end else if (state == WAIT) begin
      rd_en  = (cnt == 4'd1) && wb_cyc && !req.we;
    end
  end

  assign wr_en = (state == ACK) && req.we;

  wb_line_array #(.DEPTH(DEPTH)) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_en  (rd_en),
    .rd_adr (rd_adr),
    .rd_dat (wb_dat_s),
    .wr_en  (wr_en),
    .wr_adr (req.adr),
    .wr_sel (req.sel),
    .wr_dat (req.dat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      req    <= '0;
      wb_ack <= 1'b0;
      wb_rty <= 1'b0;
    end else begin
      wb_ack <= 1'b0;
      wb_rty <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req <= '{we: wb_we, adr: wb_adr, sel: wb_sel, dat: wb_dat_m};
            if (!in_range) begin
              state  <= RETRY;
              wb_rty <= 1'b1;
            end else if (LATENCY == 1) begin
              state  <= ACK;
              wb_ack <= 1'b1;
            end else begin
              cnt   <= 4'(LATENCY - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!wb_cyc) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state  <= ACK;
            wb_ack <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK:     state <= RELEASE;
        RETRY:   state <= RELEASE;
        RELEASE: if (!wb_stb || !wb_cyc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_line_responder.sv
// Directed bench: one LATENCY=4 and one LATENCY=1 responder sharing a bus.
module tb_wb_line_responder;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [11:0]  adr = '0;
  logic [15:0]  sel = '0;
  logic [127:0] dat_m = '0;
  logic [127:0] dat4, dat1;
  logic         ack4, rty4, ack1, rty1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_line_responder #(.DEPTH(256), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_adr(adr), .wb_sel(sel), .wb_dat_m(dat_m),
    .wb_dat_s(dat4), .wb_ack(ack4), .wb_rty(rty4)
  );

  wb_line_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_adr(adr), .wb_sel(sel), .wb_dat_m(dat_m),
    .wb_dat_s(dat1), .wb_ack(ack1), .wb_rty(rty1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request, holds STB for 'hold' cycles (or until abort_at), then idles.
  task automatic txn(input int which, input logic w, input logic [11:0] a,
                     input logic [15:0] s, input logic [127:0] d,
                     input int hold, input int abort_at,
                     output int n_ack, output int ack_cyc,
                     output int n_rty, output int rty_cyc,
                     output logic [127:0] rdat);
    logic o_ack, o_rty, both;
    both = 1'b0;
    n_ack = 0; ack_cyc = -1; n_rty = 0; rty_cyc = -1; rdat = '0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_m = d;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      o_ack = (which == 1) ? ack1 : ack4;
      o_rty = (which == 1) ? rty1 : rty4;
      if (o_ack && o_rty) both = 1'b1;
      if (o_ack) begin
        n_ack++;
        if (ack_cyc < 0) ack_cyc = i;
        rdat = (which == 1) ? dat1 : dat4;
      end
      if (o_rty) begin
        n_rty++;
        if (rty_cyc < 0) rty_cyc = i;
      end
      if (i == abort_at) begin cyc = 1'b0; stb = 1'b0; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ack_rty_exclusive", 128'(both), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int na, ac, nr, rc;
    logic [127:0] rd;
    logic [127:0] d1, d2, d3, aa, bb, part;
    d1   = 128'h00112233445566778899AABBCCDDEEFF;
    d2   = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
    d3   = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    aa   = {16{8'hAA}};
    bb   = {16{8'hBB}};
    part = {{14{8'hAA}}, {2{8'hBB}}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack4", 128'(ack4), 128'd0);
    chk("rst_rty4", 128'(rty4), 128'd0);
    chk("rst_dat4", dat4, 128'd0);
    chk("rst_dat1", dat1, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-line write then read
    txn(4, 1'b1, 12'h010, 16'hFFFF, d1, 8, 0, na, ac, nr, rc, rd);
    chk("wr_full_nack", 128'(na), 128'd1);
    chk("wr_full_acyc", 128'(ac), 128'd4);
    chk("wr_full_nrty", 128'(nr), 128'd0);
    txn(4, 1'b0, 12'h010, 16'h0000, '0, 8, 0, na, ac, nr, rc, rd);
    chk("rd_full_nack", 128'(na), 128'd1);
    chk("rd_full_acyc", 128'(ac), 128'd4);
    chk("rd_full_data", rd, d1);
    chk("rd_full_hold", dat4, d1);

    // Partial write over an all-AA line
    txn(4, 1'b1, 12'h010, 16'hFFFF, aa, 8, 0, na, ac, nr, rc, rd);
    txn(4, 1'b1, 12'h010, 16'h0003, bb, 8, 0, na, ac, nr, rc, rd);
    chk("wr_part_acyc", 128'(ac), 128'd4);
    txn(4, 1'b0, 12'h010, 16'h0000, '0, 8, 0, na, ac, nr, rc, rd);
    chk("rd_part_data", rd, part);

    // sel=0 write still ACKs and leaves the line alone
    txn(4, 1'b1, 12'h010, 16'h0000, '0, 8, 0, na, ac, nr, rc, rd);
    chk("wr_sel0_nack", 128'(na), 128'd1);
    chk("wr_sel0_acyc", 128'(ac), 128'd4);
    txn(4, 1'b0, 12'h010, 16'h0000, '0, 8, 0, na, ac, nr, rc, rd);
    chk("rd_sel0_data", rd, part);

    // Out of range with STB held: one RTY, no ACK, read data undisturbed
    txn(4, 1'b0, 12'h100, 16'h0000, '0, 8, 0, na, ac, nr, rc, rd);
    chk("oor_nrty", 128'(nr), 128'd1);
    chk("oor_rcyc", 128'(rc), 128'd1);
    chk("oor_nack", 128'(na), 128'd0);
    chk("oor_dat_hold", dat4, part);

    // Highest legal line
    txn(4, 1'b1, 12'h0FF, 16'hFFFF, d2, 8, 0, na, ac, nr, rc, rd);
    chk("top_wr_nrty", 128'(nr), 128'd0);
    txn(4, 1'b0, 12'h0FF, 16'h0000, '0, 8, 0, na, ac, nr, rc, rd);
    chk("top_rd_acyc", 128'(ac), 128'd4);
    chk("top_rd_data", rd, d2);

    // Abort: CYC dropped in cycle 2 of a write
    txn(4, 1'b1, 12'h020, 16'hFFFF, d3, 8, 0, na, ac, nr, rc, rd);
    txn(4, 1'b1, 12'h020, 16'hFFFF, '0, 8, 2, na, ac, nr, rc, rd);
    chk("abort_nack", 128'(na), 128'd0);
    txn(4, 1'b0, 12'h020, 16'h0000, '0, 8, 0, na, ac, nr, rc, rd);
    chk("abort_rd_data", rd, d3);

    // Reset in cycle 2 of a read
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ack", 128'(ack4), 128'd0);
    chk("midrst_rty", 128'(rty4), 128'd0);
    chk("midrst_dat", dat4, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(4, 1'b0, 12'h010, 16'h0000, '0, 8, 0, na, ac, nr, rc, rd);
    chk("postrst_acyc", 128'(ac), 128'd4);
    chk("postrst_data", rd, part);

    // LATENCY=1: preload lines 1 and 2
    txn(1, 1'b1, 12'h001, 16'hFFFF, d1, 3, 0, na, ac, nr, rc, rd);
    chk("l1_wr_acyc", 128'(ac), 128'd1);
    chk("l1_wr_nack", 128'(na), 128'd1);
    txn(1, 1'b1, 12'h002, 16'hFFFF, d2, 3, 0, na, ac, nr, rc, rd);
    chk("l1_wr2_acyc", 128'(ac), 128'd1);

    // LATENCY=1 back-to-back reads with a one-cycle STB gap
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h001;
    @(posedge clk); #1;
    chk("l1_b2b_ack_a", 128'(ack1), 128'd1);
    chk("l1_b2b_dat_a", dat1, d1);
    @(posedge clk); #1;
    chk("l1_b2b_release", 128'(ack1), 128'd0);
    stb = 1'b0; adr = 12'h002;
    @(posedge clk); #1;
    chk("l1_b2b_idle", 128'(ack1), 128'd0);
    stb = 1'b1;
    @(posedge clk); #1;
    chk("l1_b2b_ack_b", 128'(ack1), 128'd1);
    chk("l1_b2b_dat_b", dat1, d2);
    @(posedge clk); #1;
    chk("l1_b2b_single", 128'(ack1), 128'd0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_line_responder.md
# wb_line_responder

Wishbone slave that serves 128-bit cache lines from internal line storage with a fixed, parameterised access latency. It is the memory-side responder for the line-fetching masters (stream buffer, caches) and stands in for physical memory on their `wb` master port. It supports byte-enabled line writes, signals RTY for out-of-range line addresses, and aborts cleanly when the master drops CYC.

## Interface
- DEPTH, 256: number of 128-bit lines stored; valid line addresses are 0..DEPTH-1 (DEPTH ≤ 4096).
- LATENCY, 4: cycles from request acceptance to ACK; legal range 1..15.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- wb_cyc  in  1  bus cycle in progress.
- wb_stb  in  1  request strobe.
- wb_we  in  1  1 = write line, 0 = read line.
- wb_adr  in  12  line address (byte address [15:4]).
- wb_sel  in  16  byte enables for writes, bit i maps to byte i (bits [8i+7:8i]).
- wb_dat_m  in  128  write data.
- wb_dat_s  out  128  read data.
- wb_ack  out  1  single-cycle completion pulse.
- wb_rty  out  1  single-cycle retry pulse for a rejected request.

## Operation
- FSM states: IDLE, WAIT, ACK, RETRY, RELEASE.
- IDLE: when wb_cyc & wb_stb, latch adr, we, sel and dat_m.
  - If adr ≥ DEPTH, go to RETRY.
  - Otherwise load the counter with LATENCY-1 and go to WAIT (LATENCY=1 goes straight to ACK).
- WAIT: decrement the counter each cycle; at 0 go to ACK. Any cycle with wb_cyc=0 aborts to IDLE with no access and no ACK. wb_stb/wb_adr changes during WAIT are ignored.
- ACK: wb_ack=1 for exactly this cycle.
  - Read: wb_dat_s = stored line at the latched address, valid in this cycle.
  - Write: each byte with sel=1 is committed at the end of this cycle; bytes with sel=0 are unchanged. sel=0 writes still ACK.
  - Then go to RELEASE.
- RETRY: wb_rty=1 for one cycle, no storage access, then go to RELEASE.
- RELEASE: wait until wb_stb=0 or wb_cyc=0, then go to IDLE. This prevents a held strobe from being re-accepted as a new request.
- wb_ack and wb_rty are never high in the same cycle.
- wb_dat_s holds the last read line until the next read ACK.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, counter 0, wb_ack=0, wb_rty=0, wb_dat_s=0.
  - Reset mid-transaction discards the request; any write not yet in ACK is not committed.
  - Storage contents are not cleared by reset.
- Request sampled at edge 0. ACK is high in cycle LATENCY (edge-relative). Next request is accepted no earlier than cycle LATENCY+2, since RELEASE takes at least one cycle.
- RTY is high in cycle 1 after acceptance.
- Read data comes from the registered storage read that is launched on the final WAIT cycle (or at acceptance when LATENCY=1), so it is available in ACK.
- Read-after-write to the same line in back-to-back transactions returns the new data, because the write commits before the next acceptance.

## Structure
- Shared package lc3b_types gains:
  - lc3b_line (128-bit)
  - lc3b_line_addr (12-bit)
  - lc3b_line_sel (16-bit)
- FSM state enum is local to the module.
- One sub-module: wb_line_array, a DEPTH×128 storage with per-byte write enable and a registered read port.
- The FSM and latency counter live in wb_line_responder.

## Test plan
- Write then read, LATENCY=4: write adr 0x010, sel 0xFFFF, data 0x0011…FF → ACK in cycle 4. Read adr 0x010 → ACK in cycle 4 with wb_dat_s=0x0011…FF.
- Partial write: line 0x010 preloaded with all 0xAA; write sel 0x0003, data 0x…BBBB → read returns bytes 0-1 = 0xBB and bytes 2-15 = 0xAA.
- Out of range, DEPTH=256: read adr 0x100 → wb_rty=1 in cycle 1, no ACK; holding STB high produces no second RTY until STB drops.
- Abort: write request to adr 0x020, then wb_cyc=0 in cycle 2 → no ACK, and line 0x020 is unchanged on readback.
- Reset mid-WAIT: rst_n=0 in cycle 2 of a read → wb_ack=0, wb_dat_s=0, FSM in IDLE; a new request after reset ACKs in cycle LATENCY.
- LATENCY=1 back-to-back: read adr 1, drop STB for 1 cycle, read adr 2 → ACKs in cycle 1 of each transaction with the correct distinct data.
